wb_arbiter_n_masters: RTL and testbench
=======================================

# wb_arbiter_n_masters

Parametrised Wishbone arbiter granting one of NUM_MASTERS bus masters access to a single shared Wishbone slave, typically block RAM or a memory interconnect port. It generalises the fixed two-master arbiter: configurable master count and bus widths, a selectable fixed-priority or round-robin policy, a grant-hold limit for fairness, and grant/busy status outputs for debug and simulation top-levels.

## Interface
- NUM_MASTERS, 2: number of masters, 2..16.
- DATA_WIDTH, 32: data bus width; must be a multiple of 8.
- ADDR_WIDTH, 32: address bus width.
- PRIORITY_MODE, 0: 0 = fixed priority, lowest index wins; 1 = round robin.
- MAX_HOLD, 0: maximum cycles a grant may last while another master is requesting; 0 = unlimited.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- i_m_we / i_m_stb / i_m_cyc  in  NUM_MASTERS each  per-master strobes; bit k belongs to master k.
- i_m_sel  in  NUM_MASTERS*DATA_WIDTH/8  byte selects; slice k belongs to master k.
- i_m_dat  in  NUM_MASTERS*DATA_WIDTH  write data.
- i_m_adr  in  NUM_MASTERS*ADDR_WIDTH  address.
- o_m_dat  out  NUM_MASTERS*DATA_WIDTH  read data; zero in every slice except the granted one.
- o_m_ack  out  NUM_MASTERS  ack; only the granted bit can be high.
- o_m_int  out  NUM_MASTERS  slave interrupt, copied to every master.
- o_s_we / o_s_stb / o_s_cyc  out  1  to slave.
- o_s_sel  out  DATA_WIDTH/8;  o_s_dat  out  DATA_WIDTH;  o_s_adr  out  ADDR_WIDTH  to slave.
- i_s_dat  in  DATA_WIDTH;  i_s_ack  in  1;  i_s_int  in  1  from slave.
- o_grant  out  NUM_MASTERS  one-hot registered grant; all zero when idle.
- o_busy  out  1  high while any grant is held.

## Operation
- Two states:
  - IDLE: no grant; all slave outputs driven 0.
  - GRANT: exactly one o_grant bit set. Slave outputs mux the granted master's we/stb/cyc/sel/dat/adr. o_m_ack[g] = i_s_ack & i_m_stb[g]. o_m_dat slice g = i_s_dat.
- IDLE -> GRANT: on the first edge where any i_m_cyc is high, register the winner.
  - Fixed mode: lowest requesting index.
  - Round-robin mode: first requester searching upward from last_grant+1, wrapping at NUM_MASTERS-1 -> 0. last_grant is updated on each grant.
- GRANT -> IDLE:
  - on the edge where i_m_cyc[g] is sampled low; or
  - when MAX_HOLD != 0, hold_cnt reaches MAX_HOLD, another master is requesting, and no strobe is outstanding (i_m_stb[g] low, or i_s_ack high this cycle). This is a forced release: the current master loses the grant and re-arbitrates like any other requester.
- hold_cnt: clears on every new grant, increments each GRANT cycle, saturates at MAX_HOLD.
- Inactive masters: o_m_ack bits and o_m_dat slices are held 0 and never see slave responses.
- Interrupts: o_m_int = {NUM_MASTERS{i_s_int}}, combinational, independent of grant.
- Reset (asynchronous, active-low):
  - state = IDLE, o_grant = 0, o_busy = 0, hold_cnt = 0, all slave outputs 0, all o_m_ack 0, all o_m_dat 0.
  - last_grant = NUM_MASTERS-1, so master 0 wins first in round-robin mode.
  - Reset asserted mid-transfer aborts it immediately; the master sees no ack.

## Timing
- Grant latency: a request at edge N is granted at edge N+1; slave outputs are valid from N+1 onward.
- Release: cyc low sampled at edge N gives IDLE after N. A pending request is granted at N+1, so there is exactly one idle cycle between grants and slave cyc is low for at least one cycle.
- Ack path is combinational (slave -> master); the arbiter adds zero latency per transfer within a grant.
- Simultaneous requests are resolved in a single cycle by the policy; no request is lost.
- Round-robin fairness: with all masters requesting continuously and releasing after one transfer, each master is granted once every NUM_MASTERS grants.
- A master dropping cyc in the same cycle it would win is not granted: only the sampled request counts.

## Test plan
- Reset: drive rst=0 during active requests -> o_grant=0, o_busy=0, o_s_cyc=0, all o_m_ack=0. Release rst with m0 requesting -> o_grant=4'b0001 one edge later.
- Fixed priority, NUM_MASTERS=4: m1 and m3 request together -> m1 granted. m1 writes 0xDEADBEEF to address 0x10, BRAM acks, m1 drops cyc -> one idle cycle, then m3 granted. m3 reads 0x10 -> 0xDEADBEEF in m3's o_m_dat slice; other slices stay 0.
- Round robin: all four masters request continuously with single-word transfers -> grant order 0,1,2,3,0,1; o_s_cyc low exactly one cycle between grants.
- MAX_HOLD=8, round robin: m0 holds cyc doing back-to-back reads while m2 requests -> m0 released after its transfer completing at hold_cnt=8, m2 granted next. With m2 idle, m0 keeps the grant past 8 cycles.
- Ack isolation: slave acks while m1 granted and m0 also asserts stb -> o_m_ack=4'b0010; m0 ack stays 0.
- Interrupt: pulse i_s_int for 1 cycle while idle and while granted -> all o_m_int bits follow in the same cycle.

Source files
------------

// File: rtl/wb_arbiter_n_masters.sv
// rtl/wb_arbiter_n_masters.sv - Wishbone arbiter sharing one slave between NUM_MASTERS masters
//
// Ports:
//   clk, rst                   clock and asynchronous active-low reset
//   i_m_we/stb/cyc             per-master strobes, bit k = master k
//   i_m_sel/dat/adr            per-master byte selects, write data, address (slice k = master k)
//   o_m_dat/ack                per-master read data and ack, only the granted slice/bit is live
//   o_m_int                    slave interrupt broadcast to every master
//   o_s_we/stb/cyc/sel/dat/adr granted master's request towards the slave, zero when idle
//   i_s_dat/ack/int            slave response
//   o_grant, o_busy            one-hot registered grant and grant-held flag
module wb_arbiter_n_masters #(
    parameter int NUM_MASTERS   = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_HOLD      = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_MASTERS-1:0]             i_m_we,
    input  logic [NUM_MASTERS-1:0]             i_m_stb,
    input  logic [NUM_MASTERS-1:0]             i_m_cyc,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] i_m_sel,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  i_m_dat,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  i_m_adr,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]  o_m_dat,
    output logic [NUM_MASTERS-1:0]             o_m_ack,
    output logic [NUM_MASTERS-1:0]             o_m_int,
    output logic                               o_s_we,
    output logic                               o_s_stb,
    output logic                               o_s_cyc,
    output logic [DATA_WIDTH/8-1:0]            o_s_sel,
    output logic [DATA_WIDTH-1:0]              o_s_dat,
    output logic [ADDR_WIDTH-1:0]              o_s_adr,
    input  logic [DATA_WIDTH-1:0]              i_s_dat,
    input  logic                               i_s_ack,
    input  logic                               i_s_int,
    output logic [NUM_MASTERS-1:0]             o_grant,
    output logic                               o_busy
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   cand;
    logic            found;
    logic [HW-1:0]   hold_cnt;
    logic            cur_cyc;
    logic            cur_stb;
    logic            others_req;
    logic            hold_expired;
    logic            release_grant;

    // Winner among the masters sampling cyc high this edge.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        if (PRIORITY_MODE == 0) begin
            // Scan downward so the lowest requesting index is the last write.
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (i_m_cyc[i]) winner = IW'(i);
            end
        end else begin
            // Search starts just after the previous owner and wraps.
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                cand = IW'((int'(last_grant) + i) % NUM_MASTERS);
                if (!found && i_m_cyc[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    assign cur_cyc    = |(i_m_cyc & o_grant);
    assign cur_stb    = |(i_m_stb & o_grant);
    assign others_req = |(i_m_cyc & ~o_grant);

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));

    // A forced release only happens between transfers so no strobe is cut off.
    assign release_grant = !cur_cyc ||
                           (hold_expired && others_req && (!cur_stb || i_s_ack));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            hold_cnt   <= '0;
            last_grant <= IW'(NUM_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|i_m_cyc) begin
                        state      <= GRANT;
                        o_grant    <= NUM_MASTERS'(1) << winner;
                        o_busy     <= 1'b1;
                        hold_cnt   <= '0;
                        last_grant <= winner;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state   <= IDLE;
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                    end else if (hold_cnt != HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Request mux and response demux follow the registered one-hot grant,
    // so an idle arbiter drives zeros everywhere.
    always_comb begin
        o_s_we  = |(i_m_we & o_grant);
        o_s_stb = cur_stb;
        o_s_cyc = cur_cyc;
        o_s_sel = '0;
        o_s_dat = '0;
        o_s_adr = '0;
        o_m_dat = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (o_grant[k]) begin
                o_s_sel = i_m_sel[k*SW +: SW];
                o_s_dat = i_m_dat[k*DATA_WIDTH +: DATA_WIDTH];
                o_s_adr = i_m_adr[k*ADDR_WIDTH +: ADDR_WIDTH];
                o_m_dat[k*DATA_WIDTH +: DATA_WIDTH] = i_s_dat;
            end
        end
    end

    assign o_m_ack = o_grant & i_m_stb & {NUM_MASTERS{i_s_ack}};
    assign o_m_int = {NUM_MASTERS{i_s_int}};

endmodule

// File: tb/tb_wb_arbiter_n_masters.sv
// tb/tb_wb_arbiter_n_masters.sv - scoreboard bench for wb_arbiter_n_masters (fixed and round-robin)
module tb_wb_arbiter_n_masters;

    typedef struct {
        logic [3:0]   grant;
        logic         busy;
        logic         s_cyc;
        logic         s_stb;
        logic         s_we;
        logic [3:0]   s_sel;
        logic [31:0]  s_dat;
        logic [31:0]  s_adr;
        logic [3:0]   ack;
        logic [127:0] mdat;
        logic [3:0]   mint;
    } exp_t;

    logic clk;
    logic rst;
    logic s_int;

    logic [3:0]   m_we[2];
    logic [3:0]   m_stb[2];
    logic [3:0]   m_cyc[2];
    logic [15:0]  m_sel[2];
    logic [127:0] m_dat[2];
    logic [127:0] m_adr[2];
    logic [127:0] g_mdat[2];
    logic [3:0]   g_ack[2];
    logic [3:0]   g_int[2];
    logic [3:0]   g_grant[2];
    logic         g_busy[2];
    logic         s_we[2];
    logic         s_stb[2];
    logic         s_cyc[2];
    logic         s_ack[2];
    logic [3:0]   s_sel[2];
    logic [31:0]  s_dat[2];
    logic [31:0]  s_adr[2];
    logic [31:0]  s_rdat[2];
    logic [31:0]  smem[2][16];

    // Instance 0: fixed priority, unlimited hold. Instance 1: round robin, MAX_HOLD=8.
    wb_arbiter_n_masters #(.NUM_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                           .PRIORITY_MODE(0), .MAX_HOLD(0)) dut_fix (
        .clk(clk), .rst(rst),
        .i_m_we(m_we[0]), .i_m_stb(m_stb[0]), .i_m_cyc(m_cyc[0]),
        .i_m_sel(m_sel[0]), .i_m_dat(m_dat[0]), .i_m_adr(m_adr[0]),
        .o_m_dat(g_mdat[0]), .o_m_ack(g_ack[0]), .o_m_int(g_int[0]),
        .o_s_we(s_we[0]), .o_s_stb(s_stb[0]), .o_s_cyc(s_cyc[0]),
        .o_s_sel(s_sel[0]), .o_s_dat(s_dat[0]), .o_s_adr(s_adr[0]),
        .i_s_dat(s_rdat[0]), .i_s_ack(s_ack[0]), .i_s_int(s_int),
        .o_grant(g_grant[0]), .o_busy(g_busy[0])
    );

    wb_arbiter_n_masters #(.NUM_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                           .PRIORITY_MODE(1), .MAX_HOLD(8)) dut_rr (
        .clk(clk), .rst(rst),
        .i_m_we(m_we[1]), .i_m_stb(m_stb[1]), .i_m_cyc(m_cyc[1]),
        .i_m_sel(m_sel[1]), .i_m_dat(m_dat[1]), .i_m_adr(m_adr[1]),
        .o_m_dat(g_mdat[1]), .o_m_ack(g_ack[1]), .o_m_int(g_int[1]),
        .o_s_we(s_we[1]), .o_s_stb(s_stb[1]), .o_s_cyc(s_cyc[1]),
        .o_s_sel(s_sel[1]), .o_s_dat(s_dat[1]), .o_s_adr(s_adr[1]),
        .i_s_dat(s_rdat[1]), .i_s_ack(s_ack[1]), .i_s_int(s_int),
        .o_grant(g_grant[1]), .o_busy(g_busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait 16-word slave per instance; cleared while reset is low.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            s_ack[d]  = s_cyc[d] & s_stb[d];
            s_rdat[d] = smem[d][s_adr[d][3:0]];
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                for (int i = 0; i < 16; i++) smem[d][i] <= 32'h0;
            end else if (s_ack[d] && s_we[d]) begin
                smem[d][s_adr[d][3:0]] <= s_dat[d];
            end
        end
    end

    // Reference model: owner index (-1 = nobody), last owner, cycles held.
    int          owner[2];
    int          lastg[2];
    int          held[2];
    int          job[2][4];
    bit          pend[2][4];
    logic [31:0] rmem[2][16];
    logic [3:0]  lastack[2];
    exp_t        q0[$];
    exp_t        q1[$];
    int          errors;
    int          checks;

    function automatic int pick(int d);
        if (d == 0) begin
            for (int i = 0; i < 4; i++) if (m_cyc[d][i]) return i;
        end else begin
            for (int i = 1; i <= 4; i++) if (m_cyc[d][(lastg[d] + i) % 4]) return (lastg[d] + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset(int d);
        owner[d]   = -1;
        lastg[d]   = 3;
        held[d]    = 0;
        lastack[d] = 4'h0;
    endtask

    // Apply what the clock edge just did, using the inputs it sampled.
    task automatic advance(int d);
        int o;
        int mh;
        bit others;
        bit rel;
        mh = (d == 1) ? 8 : 0;
        if (!rst) begin
            model_reset(d);
            for (int i = 0; i < 16; i++) rmem[d][i] = 32'h0;
            return;
        end
        o = owner[d];
        if (o >= 0 && lastack[d][o] && m_we[d][o])
            rmem[d][m_adr[d][o*32 +: 4]] = m_dat[d][o*32 +: 32];
        for (int k = 0; k < 4; k++) begin
            if (lastack[d][k]) begin
                if (job[d][k] > 0) job[d][k]--;
                pend[d][k] = 1'b0;
            end
        end
        if (o < 0) begin
            if (m_cyc[d] != 4'h0) begin
                owner[d] = pick(d);
                lastg[d] = owner[d];
                held[d]  = 0;
            end
        end else begin
            others = (m_cyc[d] & ~(4'b0001 << o)) != 4'h0;
            rel = !m_cyc[d][o] ||
                  (mh > 0 && held[d] >= mh && others && (!m_stb[d][o] || lastack[d][o]));
            if (rel) owner[d] = -1;
            else if (held[d] < mh) held[d]++;
        end
    endtask

    task automatic drive_masters(int d);
        for (int k = 0; k < 4; k++) begin
            if (job[d][k] == 0) begin
                m_cyc[d][k] = 1'b0;
                m_stb[d][k] = 1'b0;
                pend[d][k]  = 1'b0;
                if ($urandom_range(0, 3) == 0) job[d][k] = $urandom_range(1, 20);
            end
            if (job[d][k] > 0) begin
                if ($urandom_range(0, 49) == 0) begin
                    job[d][k]   = 0;
                    m_cyc[d][k] = 1'b0;
                    m_stb[d][k] = 1'b0;
                    pend[d][k]  = 1'b0;
                end else begin
                    m_cyc[d][k] = 1'b1;
                    if (!pend[d][k]) begin
                        m_stb[d][k] = ($urandom_range(0, 4) != 0);
                        if (m_stb[d][k]) begin
                            pend[d][k]            = 1'b1;
                            m_we[d][k]            = 1'($urandom_range(0, 1));
                            m_adr[d][k*32 +: 32]  = $urandom;
                            m_dat[d][k*32 +: 32]  = $urandom;
                            m_sel[d][k*4 +: 4]    = 4'($urandom_range(0, 15));
                        end
                    end
                end
            end
        end
    endtask

    task automatic push_expected(int d);
        exp_t e;
        int   o;
        o = owner[d];
        e.grant = 4'h0; e.busy = 1'b0; e.s_cyc = 1'b0; e.s_stb = 1'b0; e.s_we = 1'b0;
        e.s_sel = 4'h0; e.s_dat = 32'h0; e.s_adr = 32'h0; e.ack = 4'h0; e.mdat = '0;
        e.mint  = {4{s_int}};
        if (o >= 0) begin
            e.grant = 4'b0001 << o;
            e.busy  = 1'b1;
            e.s_cyc = m_cyc[d][o];
            e.s_stb = m_stb[d][o];
            e.s_we  = m_we[d][o];
            e.s_sel = m_sel[d][o*4 +: 4];
            e.s_dat = m_dat[d][o*32 +: 32];
            e.s_adr = m_adr[d][o*32 +: 32];
            if (m_cyc[d][o] && m_stb[d][o]) e.ack = 4'b0001 << o;
            e.mdat[o*32 +: 32] = rmem[d][m_adr[d][o*32 +: 4]];
        end
        lastack[d] = e.ack;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h, expected %h", nm, d, $time, act, exp);
        end
    endtask

    // Monitor: compares each presented output set against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 ? q0.size() : q1.size()) > 0) begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("grant", d, 128'(g_grant[d]), 128'(e.grant));
                    chk("busy",  d, 128'(g_busy[d]),  128'(e.busy));
                    chk("s_cyc", d, 128'(s_cyc[d]),   128'(e.s_cyc));
                    chk("s_stb", d, 128'(s_stb[d]),   128'(e.s_stb));
                    chk("s_we",  d, 128'(s_we[d]),    128'(e.s_we));
                    chk("s_sel", d, 128'(s_sel[d]),   128'(e.s_sel));
                    chk("s_dat", d, 128'(s_dat[d]),   128'(e.s_dat));
                    chk("s_adr", d, 128'(s_adr[d]),   128'(e.s_adr));
                    chk("m_ack", d, 128'(g_ack[d]),   128'(e.ack));
                    chk("m_dat", d, g_mdat[d],        e.mdat);
                    chk("m_int", d, 128'(g_int[d]),   128'(e.mint));
                end
            end
        end
    end

    // Driver: inputs change 1 ns after each rising edge; reset pulses mid-traffic.
    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        s_int  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_we[d] = '0; m_stb[d] = '0; m_cyc[d] = '0;
            m_sel[d] = '0; m_dat[d] = '0; m_adr[d] = '0;
            model_reset(d);
            for (int k = 0; k < 4; k++) begin
                job[d][k]  = 0;
                pend[d][k] = 1'b0;
            end
            for (int i = 0; i < 16; i++) rmem[d][i] = 32'h0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) advance(d);
            rst = !(cyc < 3 || (cyc >= 1000 && cyc < 1002) || (cyc >= 2000 && cyc < 2003));
            if (!rst) for (int d = 0; d < 2; d++) model_reset(d);
            s_int = ($urandom_range(0, 3) == 0);
            for (int d = 0; d < 2; d++) begin
                drive_masters(d);
                push_expected(d);
            end
        end
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
